// File: rtl/apb_master_if.sv
// APB4 completer-facing bus bundle between apb_master (master modport) and
// its completer (slave modport).
interface apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_master.sv
// APB4 master: runs one SETUP->ACCESS transfer per accepted request and
// reports completion, read data and error/timeout status with a done pulse.
module apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    transfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   apb_waddr,
  input  logic [ADDR_WIDTH-1:0]   apb_raddr,
  input  logic [DATA_WIDTH-1:0]   apb_wdata,
  input  logic [DATA_WIDTH/8-1:0] strb_in,
  output logic                    apb_done,
  output logic [DATA_WIDTH-1:0]   apb_rdata,
  output logic                    apb_slverr,
  output logic                    apb_timeout,
  output logic                    busy,
  apb_master_if.master            apb
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    SETUP  = 3'b010,
    ACCESS = 3'b100
  } state_t;

  state_t                  state;
  logic [CW-1:0]           wait_cnt;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic                    timeout_hit;

  // Direction comes from `read` alone; `write` is carried for upstream symmetry.
  logic unused_write;
  assign unused_write = write;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      apb_done    <= 1'b0;
      apb_rdata   <= '0;
      apb_slverr  <= 1'b0;
      apb_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      apb_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (transfer) begin
            paddr_q  <= read ? apb_raddr : apb_waddr;
            pwrite_q <= ~read;
            pwdata_q <= read ? '0 : apb_wdata;
            pstrb_q  <= read ? '0 : strb_in;
            psel_q   <= 1'b1;
            busy     <= 1'b1;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end

        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          // A ready completer wins over a timeout landing in the same cycle.
          if (apb.PREADY) begin
            if (!pwrite_q) begin
              apb_rdata <= apb.PRDATA;
            end
            apb_slverr  <= apb.PSLVERR;
            apb_timeout <= 1'b0;
            apb_done    <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (timeout_hit) begin
            apb_slverr  <= 1'b1;
            apb_timeout <= 1'b1;
            apb_done    <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
